mmu_loop_counter: RTL and testbench

Parametrised two-level loop counter that sequences MMU tile operations. It is the successor to the single-level enable counter. It accepts programmable inner (K-depth) and outer (tile) lengths at start, and steps indices on each enable. It reports per-level last flags and gives a start/busy/finish handshake. It sits between the MMU control FSM and the systolic-array feed logic, which consumes `inner_idx_o`/`outer_idx_o` as addresses.

---
 rtl/mmu_loop_counter_pkg.sv | 17 +
 rtl/mmu_loop_counter_if.sv | 38 +++
 rtl/mmu_loop_counter_wrap_counter.sv | 42 ++++
 rtl/mmu_loop_counter.sv | 114 +++++++++++
 tb/tb_mmu_loop_counter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mmu_loop_counter_pkg.sv
// mmu_pkg: shared definitions for the MMU loop counter slice.
//   loop_state_e : sequencing FSM states (IDLE / RUN / DONE)
//   calc_width   : $clog2-based width helper, never returns less than 1
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_state_e;

  // A one-entry range still needs a one-bit signal, so clamp to 1.
  function automatic int unsigned calc_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmu_loop_counter_if.sv
// mmu_loop_counter_if: control/feed bundle of the two-level loop counter.
//   master modport : MMU control FSM side (drives start/lengths/enable/clear)
//   slave modport  : loop counter side (drives busy, indices, last flags, finish)
// Parameters must match those of the mmu_loop_counter instance it connects to.
interface mmu_loop_counter_if #(
  parameter int unsigned INNER_MAX = 16,
  parameter int unsigned OUTER_MAX = 16
);
  import mmu_pkg::*;

  localparam int unsigned IW  = calc_width(INNER_MAX);
  localparam int unsigned OW  = calc_width(OUTER_MAX);
  localparam int unsigned ILW = calc_width(INNER_MAX + 1);
  localparam int unsigned OLW = calc_width(OUTER_MAX + 1);

  logic           start_i;
  logic [ILW-1:0] inner_len_i;
  logic [OLW-1:0] outer_len_i;
  logic           en_i;
  logic           clear_i;
  logic           busy_o;
  logic [IW-1:0]  inner_idx_o;
  logic [OW-1:0]  outer_idx_o;
  logic           inner_last_o;
  logic           tile_last_o;
  logic           finish_o;

  modport master (
    output start_i, inner_len_i, outer_len_i, en_i, clear_i,
    input  busy_o, inner_idx_o, outer_idx_o, inner_last_o, tile_last_o, finish_o
  );

  modport slave (
    input  start_i, inner_len_i, outer_len_i, en_i, clear_i,
    output busy_o, inner_idx_o, outer_idx_o, inner_last_o, tile_last_o, finish_o
  );

endinterface

// File: rtl/mmu_loop_counter_wrap_counter.sv
// wrap_counter: single-level index counter that wraps to 0 after reaching limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : advance one step
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   limit_i    : terminal index (length - 1), held stable by the owner
//   idx_o      : current index (registered)
//   last_o     : idx_o == limit_i
module wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] idx_o,
  output logic         last_o
);

  logic [W-1:0] idx_q, idx_d;

  assign last_o = (idx_q == limit_i);

  // Wrapping at the terminal value instead of free-running keeps the index
  // inside [0, limit] whatever the counter width is.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = last_o ? '0 : idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/mmu_loop_counter.sv
// mmu_loop_counter: two-level (inner K-depth x outer tile) loop sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : start_i/inner_len_i/outer_len_i/en_i/clear_i in,
//                busy_o/inner_idx_o/outer_idx_o/inner_last_o/tile_last_o/finish_o out
// All outputs are decoded from registers only.
module mmu_loop_counter #(
  parameter int unsigned INNER_MAX = 16,
  parameter int unsigned OUTER_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mmu_loop_counter_if.slave  bus
);
  import mmu_pkg::*;

  localparam int unsigned IW  = calc_width(INNER_MAX);
  localparam int unsigned OW  = calc_width(OUTER_MAX);
  localparam int unsigned ILW = calc_width(INNER_MAX + 1);
  localparam int unsigned OLW = calc_width(OUTER_MAX + 1);

  loop_state_e state_q, state_d;

  logic [IW-1:0]  inner_lim_q, inner_lim_d;
  logic [OW-1:0]  outer_lim_q, outer_lim_d;
  logic [ILW-1:0] inner_sat;
  logic [OLW-1:0] outer_sat;
  logic           zero_len;
  logic           start_accept;
  logic           step;
  logic           cnt_clr;
  logic           inner_last_raw;
  logic           outer_last_raw;
  logic [IW-1:0]  inner_idx;
  logic [OW-1:0]  outer_idx;

  // Oversize lengths saturate; the stored value is length-1 so the
  // counters compare against a register rather than a subtractor.
  always_comb begin
    inner_sat = (bus.inner_len_i > ILW'(INNER_MAX)) ? ILW'(INNER_MAX) : bus.inner_len_i;
    outer_sat = (bus.outer_len_i > OLW'(OUTER_MAX)) ? OLW'(OUTER_MAX) : bus.outer_len_i;
    zero_len  = (inner_sat == '0) || (outer_sat == '0);
    inner_lim_d = zero_len ? '0 : IW'(inner_sat - ILW'(1));
    outer_lim_d = zero_len ? '0 : OW'(outer_sat - OLW'(1));
  end

  // Next-state logic; clear_i overrides everything, including a start.
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          start_accept = 1'b1;
          state_d      = zero_len ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.en_i && inner_last_raw && outer_last_raw) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.clear_i) begin
      state_d      = IDLE;
      start_accept = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inner_lim_q <= '0;
      outer_lim_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_accept) begin
        inner_lim_q <= inner_lim_d;
        outer_lim_q <= outer_lim_d;
      end
    end
  end

  assign step    = (state_q == RUN) && bus.en_i && !bus.clear_i;
  assign cnt_clr = bus.clear_i || start_accept;

  wrap_counter #(.W(IW)) u_inner (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (step),
    .clr_i   (cnt_clr),
    .limit_i (inner_lim_q),
    .idx_o   (inner_idx),
    .last_o  (inner_last_raw)
  );

  // The outer level only moves when the inner level wraps.
  wrap_counter #(.W(OW)) u_outer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (step && inner_last_raw),
    .clr_i   (cnt_clr),
    .limit_i (outer_lim_q),
    .idx_o   (outer_idx),
    .last_o  (outer_last_raw)
  );

  assign bus.busy_o       = (state_q == RUN);
  assign bus.finish_o     = (state_q == DONE);
  assign bus.inner_idx_o  = inner_idx;
  assign bus.outer_idx_o  = outer_idx;
  assign bus.inner_last_o = bus.busy_o && inner_last_raw;
  assign bus.tile_last_o  = bus.busy_o && inner_last_raw && outer_last_raw;

endmodule

// File: tb/tb_mmu_loop_counter.sv
// tb_mmu_loop_counter: directed self-checking bench for mmu_loop_counter
// (INNER_MAX = OUTER_MAX = 16). Inputs change 1 time unit after the rising
// edge and outputs are sampled there too, away from the active edge.
module tb_mmu_loop_counter;

  localparam int unsigned INNER_MAX = 16;
  localparam int unsigned OUTER_MAX = 16;

  logic clk;
  logic rst_n;

  int assertCount = 0;
  int failCount   = 0;

  mmu_loop_counter_if #(.INNER_MAX(INNER_MAX), .OUTER_MAX(OUTER_MAX)) bus ();

  mmu_loop_counter #(.INNER_MAX(INNER_MAX), .OUTER_MAX(OUTER_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input int inLen, input int outLen,
                               input logic en, input logic clr);
    bus.start_i     = start;
    bus.inner_len_i = 5'(inLen);
    bus.outer_len_i = 5'(outLen);
    bus.en_i        = en;
    bus.clear_i     = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic busy, input int inner, input int outer,
                          input logic iLast, input logic tLast, input logic fin);
    checkOutput({tag, ".busy"},   32'(bus.busy_o),       32'(busy));
    checkOutput({tag, ".inner"},  32'(bus.inner_idx_o),  32'(inner));
    checkOutput({tag, ".outer"},  32'(bus.outer_idx_o),  32'(outer));
    checkOutput({tag, ".ilast"},  32'(bus.inner_last_o), 32'(iLast));
    checkOutput({tag, ".tlast"},  32'(bus.tile_last_o),  32'(tLast));
    checkOutput({tag, ".finish"}, 32'(bus.finish_o),     32'(fin));
  endtask

  initial begin
    int s;
    int busyCycles;

    // Power-on reset
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Full 4x3 run with en_i held high
    $display("[TB] full 4x3 run");
    applyStimulus(1'b1, 4, 3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4, 3, 1'b1, 1'b0);
    busyCycles = 0;
    for (int k = 0; k < 12; k++) begin
      checkAll($sformatf("full[%0d]", k), 1'b1, k % 4, k / 4,
               (k % 4) == 3, k == 11, 1'b0);
      if (bus.busy_o) busyCycles++;
      tick();
    end
    checkOutput("full.busyCycles", 32'(busyCycles), 32'd12);
    checkAll("full.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    checkAll("full.idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Same run with en_i alternating 0,1 from the first RUN cycle
    $display("[TB] stalled 4x3 run");
    applyStimulus(1'b1, 4, 3, 1'b0, 1'b0);
    tick();
    s = 0;
    busyCycles = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b0, 4, 3, logic'(c % 2), 1'b0);
      checkAll($sformatf("stall[%0d]", c), 1'b1, s % 4, s / 4,
               (s % 4) == 3, s == 11, 1'b0);
      if (bus.busy_o) busyCycles++;
      tick();
      if ((c % 2) == 1) s++;
    end
    checkOutput("stall.busyCycles", 32'(busyCycles), 32'd24);
    checkAll("stall.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4, 3, 1'b0, 1'b0);
    tick();
    checkOutput("stall.finishOnce", 32'(bus.finish_o), 32'd0);

    // Zero inner length goes straight to DONE
    $display("[TB] zero length");
    applyStimulus(1'b1, 0, 5, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 5, 1'b1, 1'b0);
    checkAll("zero.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    checkAll("zero.idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();

    // Oversize inner length saturates to 16
    $display("[TB] oversize length");
    applyStimulus(1'b1, 31, 1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 31, 1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checkAll($sformatf("sat[%0d]", k), 1'b1, k, 0, k == 15, k == 15, 1'b0);
      tick();
    end
    checkAll("sat.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();

    // Start during RUN is ignored, then clear_i aborts at step 5
    $display("[TB] ignored start and clear");
    applyStimulus(1'b1, 4, 3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4, 3, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 2, 2, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2, 2, 1'b1, 1'b0);
    checkAll("ign.step3", 1'b1, 3, 0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("clr.step5", 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2, 2, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 2, 2, 1'b0, 1'b0);
    checkAll("clr.after", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("clr.noFinish", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Start presented only during DONE is ignored
    $display("[TB] start in DONE");
    applyStimulus(1'b1, 2, 1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2, 1, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("doneStart.finish", 32'(bus.finish_o), 32'd1);
    applyStimulus(1'b1, 3, 3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3, 3, 1'b0, 1'b0);
    checkAll("doneStart.idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("doneStart.stillIdle", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset in the middle of a 4x3 run at index 2/1
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 4, 3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4, 3, 1'b1, 1'b0);
    repeat (6) tick();
    applyStimulus(1'b0, 4, 3, 1'b0, 1'b0);
    checkAll("rst.before", 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkAll("rst.async", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    checkAll("rst.idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2, 2, 1'b0, 1'b0);
    checkAll("rst.restart", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
